iloveyou_tx: RTL
================

Name: iloveyou_tx

Overview:
- Byte-stream generator that emits the ASCII string "ILOVEYOU" one character per handshake. It is the transmit-side counterpart of the ILOVEYOU checker.
- Per-character case control, a programmable repeat count and optional idle gaps let the bench and the datapath drive the checker with hit, case-variant and back-to-back patterns.
- Sits upstream of the checker on the same 8-bit character bus.

Parameters:
- GAP, default 0: idle cycles inserted after every accepted character, including between repeats; 0 means back-to-back.
- GAP_W, default 4: width of the gap counter; GAP must be less than 2**GAP_W.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- start  input  1  single-cycle request; honoured only in IDLE
- repeat_num  input  8  number of full strings to send; sampled on accepted start
- case_mask  input  8  bit i=1 sends character i in lowercase; sampled on accepted start
- data_ready  input  1  sink can accept data_out this cycle
- data_out  output  8  ASCII character
- data_valid  output  1  data_out holds a valid character
- char_idx  output  3  index 0..7 of the character on data_out
- busy  output  1  transmission in progress
- done  output  1  one-cycle pulse at end of transmission

Behaviour:
- Reset: all state and outputs clear asynchronously while rst=1: data_out=8'h00, data_valid=0, char_idx=0, busy=0, done=0, state=IDLE, counters 0. Reset mid-string aborts it; no done pulse is generated.
- All outputs are registered.
- Character ROM, index 0..7: 8'h49 'I', 8'h4C 'L', 8'h4F 'O', 8'h56 'V', 8'h45 'E', 8'h59 'Y', 8'h4F 'O', 8'h55 'U'.
- Lowercase form is ROM value + 8'h20, applied when the latched case_mask[char_idx]=1.
- States: IDLE, SEND, GAP, DONE.
- IDLE, start=1:
  - Latch repeat_num and case_mask.
  - If repeat_num=0: go to DONE, so done=1 on the next cycle and no data is sent.
  - Otherwise: go to SEND with char_idx=0. On the next cycle data_valid=1, data_out='I' (or 'i'), busy=1. Start-to-first-valid latency is 1 cycle.
- SEND:
  - data_valid is held high. data_out and char_idx stay stable until the handshake (data_valid & data_ready).
  - On handshake, if this is not the last character of the last repeat:
    - GAP=0: next character is presented the following cycle. char_idx wraps 7->0, and the repeat counter decrements on the 7->0 wrap.
    - GAP>0: go to GAP.
  - On handshake of char_idx=7 in the final repeat: go to DONE.
- GAP:
  - data_valid=0 and data_out holds its last value; stay exactly GAP cycles.
  - Then return to SEND with the next character valid.
  - char_idx and the repeat counter advance on entry to GAP.
- DONE:
  - done=1, busy=0, data_valid=0 for exactly one cycle, then IDLE.
  - start is ignored while in DONE.
- busy=1 in SEND and GAP; 0 in IDLE and DONE.
- start while busy or in DONE is ignored; the latched repeat_num and case_mask are unaffected.
- data_ready held low indefinitely: the block waits with no timeout and outputs stay stable.
- data_ready high while data_valid=0 has no effect.
- Repeat counter is 8-bit. repeat_num=255 sends 2040 characters with no overflow.
- Throughput with GAP=0 and data_ready=1: one character per cycle.
- Total cycles from start to done with GAP=0 and data_ready=1: 8*repeat_num+1.

Test Plan:
- Basic: GAP=0, repeat_num=1, case_mask=0, data_ready=1.
  - Expected: data_out 49,4C,4F,56,45,59,4F,55 on 8 consecutive cycles starting 1 cycle after start.
  - Then done=1 for 1 cycle, busy=0.
- Case: case_mask=8'b1010_0101.
  - Expected: bytes 69,4C,6F,56,45,79,4F,75 ("iLoVEyOu"), compared byte-for-byte.
- Backpressure: data_ready low for 3 cycles while 'V' (char_idx=3) is valid.
  - Expected: data_out=8'h56 and data_valid=1 held stable for 4 cycles.
  - No character skipped or duplicated; total stream is still 8 bytes.
- Repeats and gap: GAP=2, repeat_num=3.
  - Expected: 24 characters, each followed by exactly 2 data_valid=0 cycles, including between repeats.
  - char_idx sequence 0..7 three times; one done pulse at the end.
- Corner cases:
  - repeat_num=0: done pulses 1 cycle after start, data_valid never rises.
  - start asserted during busy: ignored, stream unchanged.
  - start asserted in the done cycle: ignored.
- Reset mid-operation: assert rst after char_idx=4 handshake.
  - Expected: all outputs 0 immediately, no done pulse.
  - A new start after reset release begins again with 'I'.
- Loopback: connect to the checker.
  - Expected: checker flags one detection per completed repeat.

Source files
------------

// File: rtl/iloveyou_tx_if.sv
// Character bus between the ILOVEYOU transmitter and its sink/controller.
// The master side is the transmitter: it takes the start request and
// ready, and drives the character stream and status.
interface iloveyou_tx_if;
    logic       start;
    logic [7:0] repeat_num;
    logic [7:0] case_mask;
    logic       data_ready;
    logic [7:0] data_out;
    logic       data_valid;
    logic [2:0] char_idx;
    logic       busy;
    logic       done;

    modport master (
        input  start, repeat_num, case_mask, data_ready,
        output data_out, data_valid, char_idx, busy, done
    );

    modport slave (
        output start, repeat_num, case_mask, data_ready,
        input  data_out, data_valid, char_idx, busy, done
    );
endinterface

// File: rtl/iloveyou_tx.sv
// ILOVEYOU byte-stream generator: sends the string repeat_num times, one
// character per valid/ready handshake, with optional per-character lowercase
// and GAP idle cycles after each accepted character. All outputs registered.
module iloveyou_tx #(
    parameter int unsigned GAP   = 0,
    parameter int unsigned GAP_W = 4
) (
    input  logic          clk,
    input  logic          rst,
    iloveyou_tx_if.master bus
);
    // Uppercase ROM, character i lives in bits [8*i +: 8]: "ILOVEYOU".
    localparam logic [63:0] ROM = 64'h55_4F_59_45_56_4F_4C_49;
    // Gap counter reload value; only meaningful when GAP > 0.
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP == 0) ? 0 : GAP - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_GAP,
        ST_DONE
    } state_t;

    state_t           state_reg,      state_next;
    logic [2:0]       char_idx_reg,   char_idx_next;
    logic [7:0]       rep_reg,        rep_next;
    logic [7:0]       mask_reg,       mask_next;
    logic [GAP_W-1:0] gap_cnt_reg,    gap_cnt_next;
    logic [7:0]       data_out_reg,   data_out_next;
    logic             data_valid_reg, data_valid_next;
    logic             busy_reg,       busy_next;
    logic             done_reg,       done_next;

    logic [7:0] mask_src;
    logic [7:0] char_tab [8];
    logic       handshake;
    logic       last_char;
    logic [2:0] idx_inc;

    // The first character is loaded on the same edge that latches case_mask,
    // so in IDLE the case table must come straight from the input.
    assign mask_src  = (state_reg == ST_IDLE) ? bus.case_mask : mask_reg;
    assign handshake = data_valid_reg & bus.data_ready;
    assign last_char = (char_idx_reg == 3'd7) && (rep_reg == 8'd1);
    assign idx_inc   = char_idx_reg + 3'd1;

    // Case-adjusted character for every index.
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_char
            assign char_tab[gi] = ROM[8*gi +: 8] + (mask_src[gi] ? 8'h20 : 8'h00);
        end
    endgenerate

    // Next-state and next-output logic.
    always_comb begin
        state_next      = state_reg;
        char_idx_next   = char_idx_reg;
        rep_next        = rep_reg;
        mask_next       = mask_reg;
        gap_cnt_next    = gap_cnt_reg;
        data_out_next   = data_out_reg;
        data_valid_next = data_valid_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.start) begin
                    mask_next     = bus.case_mask;
                    rep_next      = bus.repeat_num;
                    char_idx_next = 3'd0;
                    if (bus.repeat_num == 8'd0) begin
                        state_next      = ST_DONE;
                        done_next       = 1'b1;
                        busy_next       = 1'b0;
                        data_valid_next = 1'b0;
                    end else begin
                        state_next      = ST_SEND;
                        data_out_next   = char_tab[0];
                        data_valid_next = 1'b1;
                        busy_next       = 1'b1;
                    end
                end
            end

            ST_SEND: begin
                if (handshake) begin
                    if (last_char) begin
                        state_next      = ST_DONE;
                        done_next       = 1'b1;
                        busy_next       = 1'b0;
                        data_valid_next = 1'b0;
                    end else begin
                        // Index and repeat count advance on every accepted
                        // character; the repeat count drops on the 7->0 wrap.
                        char_idx_next = idx_inc;
                        if (char_idx_reg == 3'd7) begin
                            rep_next = rep_reg - 8'd1;
                        end
                        if (GAP == 0) begin
                            data_out_next = char_tab[idx_inc];
                        end else begin
                            state_next      = ST_GAP;
                            data_valid_next = 1'b0;
                            gap_cnt_next    = GAP_LAST;
                        end
                    end
                end
            end

            ST_GAP: begin
                // data_out keeps the last character while idling.
                if (gap_cnt_reg == '0) begin
                    state_next      = ST_SEND;
                    data_out_next   = char_tab[char_idx_reg];
                    data_valid_next = 1'b1;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 1'b1;
                end
            end

            ST_DONE: begin
                state_next = ST_IDLE;
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            char_idx_reg   <= 3'd0;
            rep_reg        <= 8'd0;
            mask_reg       <= 8'd0;
            gap_cnt_reg    <= '0;
            data_out_reg   <= 8'h00;
            data_valid_reg <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            char_idx_reg   <= char_idx_next;
            rep_reg        <= rep_next;
            mask_reg       <= mask_next;
            gap_cnt_reg    <= gap_cnt_next;
            data_out_reg   <= data_out_next;
            data_valid_reg <= data_valid_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
        end
    end

    assign bus.data_out   = data_out_reg;
    assign bus.data_valid = data_valid_reg;
    assign bus.char_idx   = char_idx_reg;
    assign bus.busy       = busy_reg;
    assign bus.done       = done_reg;
endmodule
